// File: rtl/m_flits_download.sv
// m_flits_download: reassembles one ring message (head, addrhi, addrlo and up to
// 8 data halves) from a serial flit stream. It holds the message until the
// memory-side consumer acks it.
// Optional build macro M_DOWNLOAD_ERR_EN enables the sticky protocol-error flag.
// When the macro is undefined, err_out is tied low.
//
// state | meaning
// IDLE  | waiting for a head flit; non-head flits are consumed and dropped
// BUSY  | head taken, collecting body flits until tail or overflow
// FULL  | message assembled and held; input stalled until flits_ack
module m_flits_download #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 11,
  parameter int CNT_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLIT_W-1:0]              flit_in,
  input  logic [1:0]                     ctrl_in,
  input  logic                           v_flit_in,
  output logic                           rdy_out,
  input  logic                           flits_ack,
  output logic                           v_flits_out,
  output logic [FLIT_W-1:0]              head_flit,
  output logic [FLIT_W-1:0]              addrhi,
  output logic [FLIT_W-1:0]              addrlo,
  output logic [FLIT_W*(MAX_FLITS-3)-1:0] data_out,
  output logic [CNT_W-1:0]               flits_num,
  output logic [1:0]                     fsm_state,
  output logic                           err_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_FULL = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [FLIT_W-1:0]   slots [MAX_FLITS];
  logic                accept;
  logic                slot_clr;
  logic                slot_wr;
  logic [CNT_W-1:0]    slot_idx;
  logic                num_ld;
  logic [CNT_W-1:0]    num_nxt;
  logic                err_set;

  assign rdy_out     = (state != ST_FULL);
  assign accept      = v_flit_in & rdy_out;
  assign v_flits_out = (state == ST_FULL);
  assign fsm_state   = state;

  // State and flit counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode plus the slot/count/error strobes that go with each accept.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_clr  = 1'b0;
    slot_wr   = 1'b0;
    slot_idx  = cnt;
    num_ld    = 1'b0;
    num_nxt   = flits_num;
    err_set   = 1'b0;
    case (state)
      ST_IDLE, ST_BUSY: begin
        if (accept) begin
          if (ctrl_in[0]) begin
            // A head always restarts assembly, abandoning any partial message.
            slot_clr = 1'b1;
            slot_wr  = 1'b1;
            slot_idx = '0;
            err_set  = (state == ST_BUSY);
            if (ctrl_in[1]) begin
              num_ld    = 1'b1;
              num_nxt   = CNT_W'(1);
              cnt_nxt   = '0;
              state_nxt = ST_FULL;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = ST_BUSY;
            end
          end else if (state == ST_IDLE) begin
            err_set = 1'b1;
          end else begin
            slot_wr = 1'b1;
            if (ctrl_in[1] || (cnt == CNT_W'(MAX_FLITS - 1))) begin
              // Tail, or a body flit landing in the last slot, closes the message.
              num_ld    = 1'b1;
              num_nxt   = cnt + CNT_W'(1);
              cnt_nxt   = '0;
              state_nxt = ST_FULL;
              err_set   = ~ctrl_in[1];
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_FULL: begin
        if (flits_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Message slots: cleared on each head, then written one flit per accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_FLITS; i++) slots[i] <= '0;
    end else begin
      if (slot_clr) begin
        for (int i = 0; i < MAX_FLITS; i++) slots[i] <= '0;
      end
      if (slot_wr) slots[slot_idx] <= flit_in;
    end
  end

  // Flit count of the held message, updated only when a message closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flits_num <= '0;
    else if (num_ld) flits_num <= num_nxt;
  end

  assign head_flit = slots[0];
  assign addrhi    = slots[1];
  assign addrlo    = slots[2];

  for (genvar g = 0; g < MAX_FLITS - 3; g++) begin : g_data
    assign data_out[FLIT_W*(MAX_FLITS-3-g)-1 -: FLIT_W] = slots[3+g];
  end

`ifdef M_DOWNLOAD_ERR_EN
  logic err_r;

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_r <= 1'b0;
    else if (err_set) err_r <= 1'b1;
  end

  assign err_out = err_r;
`else
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign err_out        = 1'b0;
`endif

endmodule
